// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1280x1024@60 raster counters with registered sync/blank flags.
// Optional frame counter port enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter int SYNC_POL  = 1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        PIX_CE,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        LINE_START,
  output logic        FRAME_START
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] FRAME_COUNT
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // 13-bit bounds so an end-exclusive limit of 4096 still fits
  localparam logic [12:0] H_VIS = 13'(H_VISIBLE);
  localparam logic [12:0] V_VIS = 13'(V_VISIBLE);
  localparam logic [12:0] HS_B  = 13'(H_VISIBLE + H_FP);
  localparam logic [12:0] HS_E  = 13'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [12:0] VS_B  = 13'(V_VISIBLE + V_FP);
  localparam logic [12:0] VS_E  = 13'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic POL = (SYNC_POL != 0);

  logic        primed;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic [12:0] h_w;
  logic [12:0] v_w;
  logic        act_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        ls_nxt;
  logic        fs_nxt;

  // Next raster position; the priming edge presents (0,0) without moving
  always_comb begin
    h_nxt = VGA_horzCoord;
    v_nxt = VGA_vertCoord;
    if (primed) begin
      if (VGA_horzCoord == H_LAST) begin
        h_nxt = '0;
        if (VGA_vertCoord == V_LAST) begin
          v_nxt = '0;
        end else begin
          v_nxt = VGA_vertCoord + 12'd1;
        end
      end else begin
        h_nxt = VGA_horzCoord + 12'd1;
      end
    end
  end

  // Flags derived from the next position so they register alongside it
  always_comb begin
    h_w     = {1'b0, h_nxt};
    v_w     = {1'b0, v_nxt};
    act_nxt = (h_w < H_VIS) && (v_w < V_VIS);
    hs_nxt  = ((h_w >= HS_B) && (h_w < HS_E)) ? POL : ~POL;
    vs_nxt  = ((v_w >= VS_B) && (v_w < VS_E)) ? POL : ~POL;
    ls_nxt  = (h_nxt == 12'd0);
    fs_nxt  = (h_nxt == 12'd0) && (v_nxt == 12'd0);
  end

  // Raster state and output registers; pulses drop on any non-advancing edge
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      VGA_horzCoord <= '0;
      VGA_vertCoord <= '0;
      VGA_HS        <= ~POL;
      VGA_VS        <= ~POL;
      VGA_active    <= 1'b0;
      LINE_START    <= 1'b0;
      FRAME_START   <= 1'b0;
      primed        <= 1'b0;
    end else if (PIX_CE) begin
      VGA_horzCoord <= h_nxt;
      VGA_vertCoord <= v_nxt;
      VGA_HS        <= hs_nxt;
      VGA_VS        <= vs_nxt;
      VGA_active    <= act_nxt;
      LINE_START    <= ls_nxt;
      FRAME_START   <= fs_nxt;
      primed        <= 1'b1;
    end else begin
      LINE_START    <= 1'b0;
      FRAME_START   <= 1'b0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises FRAME_START
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      FRAME_COUNT <= '0;
    end else if (PIX_CE && fs_nxt) begin
      FRAME_COUNT <= FRAME_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default-size and a reduced-size raster.
// The small instance (20x12 total, negative sync) makes whole frames cheap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  logic [11:0] hc, vc, hc_s, vc_s;
  logic hs, vs, act, ls, fs;
  logic hs_s, vs_s, act_s, ls_s, fs_s;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc, fc_s;
`endif

  vga_timing_gen dut (
    .CLK_VGA(clk),
    .RESET(rst),
    .PIX_CE(ce),
    .VGA_horzCoord(hc),
    .VGA_vertCoord(vc),
    .VGA_HS(hs),
    .VGA_VS(vs),
    .VGA_active(act),
    .LINE_START(ls),
    .FRAME_START(fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .FRAME_COUNT(fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(0)
  ) dut_s (
    .CLK_VGA(clk),
    .RESET(rst),
    .PIX_CE(ce),
    .VGA_horzCoord(hc_s),
    .VGA_vertCoord(vc_s),
    .VGA_HS(hs_s),
    .VGA_VS(vs_s),
    .VGA_active(act_s),
    .LINE_START(ls_s),
    .FRAME_START(fs_s)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .FRAME_COUNT(fc_s)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errs, p, col, row, k0, k1;
    logic en;

    #1 rst = 1'b1;
    #2;
    chk("rst_hc", int'(hc), 0);
    chk("rst_vc", int'(vc), 0);
    chk("rst_hs", int'(hs), 0);
    chk("rst_vs", int'(vs), 0);
    chk("rst_act", int'(act), 0);
    chk("rst_ls", int'(ls), 0);
    chk("rst_fs", int'(fs), 0);
    chk("rst_hs_s", int'(hs_s), 1);
    chk("rst_vs_s", int'(vs_s), 1);

    step();
    rst = 1'b0;
    ce = 1'b1;
    step();
    chk("prime_hc", int'(hc), 0);
    chk("prime_vc", int'(vc), 0);
    chk("prime_act", int'(act), 1);
    chk("prime_fs", int'(fs), 1);
    chk("prime_ls", int'(ls), 1);
    step();
    chk("second_hc", int'(hc), 1);
    chk("second_fs", int'(fs), 0);
    chk("second_ls", int'(ls), 0);

    errs = 0;
    for (int i = 2; i <= 1688; i++) begin
      step();
      col = i % 1688;
      row = i / 1688;
      if (int'(hc) != col || int'(vc) != row) errs++;
      if (hs !== (col >= 1328 && col <= 1439)) errs++;
      if (act !== (col < 1280)) errs++;
      if (ls !== (col == 0)) errs++;
      if (fs !== 1'b0) errs++;
      case (col)
        1279: chk("act_1279", int'(act), 1);
        1280: chk("act_1280", int'(act), 0);
        1327: chk("hs_1327", int'(hs), 0);
        1328: chk("hs_1328", int'(hs), 1);
        1439: chk("hs_1439", int'(hs), 1);
        1440: chk("hs_1440", int'(hs), 0);
        0: begin
          chk("wrap_row", int'(vc), 1);
          chk("wrap_ls", int'(ls), 1);
        end
        default: ;
      endcase
    end
    chk("line_scan", errs, 0);

    rst = 1'b1;
    step();
    chk("rst_ce_fs_s", int'(fs_s), 0);
    rst = 1'b0;
    step();
    chk("s_prime_fs", int'(fs_s), 1);
    chk("s_prime_hc", int'(hc_s), 0);
`ifdef VGA_FRAME_COUNT_EN
    chk("fc_first", int'(fc_s), 1);
`endif

    errs = 0;
    k0 = -1;
    k1 = -1;
    for (int k = 1; k <= 480; k++) begin
      step();
      col = k % 20;
      row = (k / 20) % 12;
      if (int'(hc_s) != col || int'(vc_s) != row) errs++;
      if (vs_s !== !(row >= 7 && row <= 8)) errs++;
      if (hs_s !== !(col >= 12 && col <= 14)) errs++;
      if (act_s !== (col < 10 && row < 6)) errs++;
      if (ls_s !== (col == 0)) errs++;
      if (fs_s) begin
        if (k0 < 0) k0 = k;
        else if (k1 < 0) k1 = k;
      end
      if (k == 139) chk("vs_row6", int'(vs_s), 1);
      if (k == 140) chk("vs_row7", int'(vs_s), 0);
      if (k == 180) chk("vs_row9", int'(vs_s), 1);
      if (k == 239) begin
        chk("last_hc", int'(hc_s), 19);
        chk("last_vc", int'(vc_s), 11);
      end
      if (k == 240) begin
        chk("fwrap_hc", int'(hc_s), 0);
        chk("fwrap_vc", int'(vc_s), 0);
        chk("fwrap_fs", int'(fs_s), 1);
        chk("fwrap_ls", int'(ls_s), 1);
      end
    end
    chk("frame_scan", errs, 0);
    chk("fs_first", k0, 240);
    chk("fs_gap", k1 - k0, 240);
`ifdef VGA_FRAME_COUNT_EN
    chk("fc_two", int'(fc_s), 3);
`endif

    errs = 0;
    p = 0;
    for (int c = 0; c < 60; c++) begin
      en = (c % 3 == 2);
      ce = en;
      step();
      if (en) p++;
      col = p % 20;
      row = (p / 20) % 12;
      if (int'(hc_s) != col || int'(vc_s) != row) errs++;
      if (ls_s !== (en && col == 0)) errs++;
      if (fs_s !== (en && col == 0 && row == 0)) errs++;
    end
    chk("ce_scan", errs, 0);
    chk("ce_hc", int'(hc_s), 0);
    chk("ce_vc", int'(vc_s), 1);
    chk("ce_ls", int'(ls_s), 1);
    ce = 1'b0;
    step();
    chk("ce_ls_clr", int'(ls_s), 0);
    chk("ce_hold", int'(vc_s), 1);

    ce = 1'b1;
    repeat (85) step();
    chk("mid_hc", int'(hc_s), 5);
    chk("mid_vc", int'(vc_s), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_hc", int'(hc_s), 0);
    chk("arst_vc", int'(vc_s), 0);
    chk("arst_act", int'(act_s), 0);
    chk("arst_hs", int'(hs_s), 1);
    chk("arst_vs", int'(vs_s), 1);
    step();
    chk("arst_win_hc", int'(hc_s), 0);
    chk("arst_win_fs", int'(fs_s), 0);
    rst = 1'b0;
    step();
    chk("re_fs", int'(fs_s), 1);
    chk("re_ls", int'(ls_s), 1);
    chk("re_act", int'(act_s), 1);
    chk("re_hc", int'(hc_s), 0);
`ifdef VGA_FRAME_COUNT_EN
    chk("re_fc", int'(fc_s), 1);
`endif
    step();
    chk("re2_hc", int'(hc_s), 1);
    chk("re2_fs", int'(fs_s), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 1280x1024@60 Hz VGA raster timing: horizontal/vertical pixel counters, sync pulses and blanking qualification. It drives the `VGA_horzCoord`/`VGA_vertCoord` buses that every overlay, label and waveform pixel-condition block in the oscilloscope display consumes, so those blocks only ever see coordinates and flags that are mutually consistent. All outputs are registered. Counting is gated by a pixel clock-enable.

## Interface
- `H_VISIBLE`, default 1280: active pixels per line.
- `H_FP`, default 48: horizontal front porch, in pixels.
- `H_SYNC`, default 112: horizontal sync width, in pixels.
- `H_BP`, default 248: horizontal back porch. H_TOTAL = 1688.
- `V_VISIBLE`, default 1024: active lines per frame.
- `V_FP`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 3: vertical sync width, in lines.
- `V_BP`, default 38: vertical back porch. V_TOTAL = 1066.
- `SYNC_POL`, default 1: asserted level of `VGA_HS`/`VGA_VS` (1 = positive sync).
- `CLK_VGA`, in, 1: pixel-domain clock (108 MHz nominal).
- `RESET`, in, 1: **one clock; reset is asynchronous and active-high**.
- `PIX_CE`, in, 1: advance-enable; the raster moves one pixel per rising edge with `PIX_CE`=1.
- `VGA_horzCoord`, out, 12: current column, 0..H_TOTAL-1.
- `VGA_vertCoord`, out, 12: current row, 0..V_TOTAL-1.
- `VGA_HS`, out, 1: horizontal sync.
- `VGA_VS`, out, 1: vertical sync.
- `VGA_active`, out, 1: current coordinate is inside the visible area.
- `LINE_START`, out, 1: one-cycle pulse when column 0 is presented.
- `FRAME_START`, out, 1: one-cycle pulse when (0,0) is presented.
- `FRAME_COUNT`, out, 16: present only with `VGA_FRAME_COUNT_EN`.

## Operation
- State: horizontal counter, vertical counter, and a `primed` flag.
- Reset (async, immediate, also mid-frame):
  - coordinates 0/0;
  - `VGA_HS` = `VGA_VS` = !SYNC_POL;
  - `VGA_active`, `LINE_START`, `FRAME_START` = 0;
  - `primed` = 0;
  - `FRAME_COUNT` = 0.
- First `PIX_CE` edge with `primed`=0:
  - coordinates stay at (0,0); flags are loaded for (0,0): active=1, LINE_START=1, FRAME_START=1;
  - `primed` is set.
- Each later `PIX_CE` edge:
  - column increments;
  - at column H_TOTAL-1 it wraps to 0 and the row increments;
  - at row V_TOTAL-1 with column wrap, the row wraps to 0.
- Flags always describe the coordinate pair presented in the same cycle (no skew):
  - `VGA_active` = col < H_VISIBLE && row < V_VISIBLE.
  - `VGA_HS` asserted for col in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [1328, 1439] at defaults.
  - `VGA_VS` asserted for row in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [1025, 1027], over whole lines.
- All flags are computed from next-state counter values and registered; no combinational output paths.
- Arithmetic: 12-bit unsigned. Totals must be ≤ 4096; larger totals are a configuration error and unsupported.

## Timing
- Latency: one `CLK_VGA` edge with `PIX_CE`=1 → new coordinate and matching flags valid after that edge.
- `PIX_CE`=0: coordinates, HS, VS and active hold.
- `LINE_START`/`FRAME_START` last exactly one `CLK_VGA` cycle. They clear on the next edge regardless of `PIX_CE`.
- Simultaneous column and row wrap: (H_TOTAL-1, V_TOTAL-1) → (0,0) in one edge, with `FRAME_START` and `LINE_START` both pulsed.
- `RESET` asserted together with `PIX_CE`: reset wins.

## Configuration
- `VGA_FRAME_COUNT_EN` defined:
  - `FRAME_COUNT` port exists;
  - it increments on the same edge that raises `FRAME_START`, including the primed first frame;
  - 16-bit wrap 65535→0; reset 0.
- `VGA_FRAME_COUNT_EN` undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `PIX_CE`=1 continuously → first cycle shows (0,0), active=1, FRAME_START=1, LINE_START=1; next cycle shows (1,0) with both pulses 0.
- Run one line → HS rises when the column reaches 1328 and falls at 1440; active falls at 1280; at 1687→0 the row becomes 1 and LINE_START pulses.
- Run a full frame → VS high only for rows 1025–1027; (1687,1065)→(0,0) with FRAME_START; exactly 1688×1066 = 1 799 408 enabled cycles between FRAME_START pulses.
- Toggle `PIX_CE` 1-in-3 → coordinates advance once per enabled edge and hold otherwise; each pulse is exactly one `CLK_VGA` wide.
- Assert `RESET` asynchronously at (700,500) mid-cycle → outputs reach reset values before the next edge; restart repeats the primed (0,0) behaviour.
- With `VGA_FRAME_COUNT_EN` → count 1 after the first FRAME_START, 3 after two full frames; forced to 65535, the next frame gives 0.
